voice_activity_detector: RTL and testbench



---
 rtl/voice_activity_detector.sv | 161 ++++++++++++++++
 tb/tb_voice_activity_detector.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/voice_activity_detector.sv
// Windowed mean-|x| loudness meter with a hysteretic voice-activity decision.
// Pipeline: |x| capture -> window accumulate -> mean, level and FSM update on window close.
module voice_activity_detector #(
    parameter int          WINDOW_LOG2    = 8,
    parameter logic [31:0] ON_THRESH      = 32'h0010_0000,
    parameter logic [31:0] OFF_THRESH     = 32'h0008_0000,
    parameter int          ATTACK_WINDOWS = 2,
    parameter int          HANG_WINDOWS   = 4,
    parameter int          LEVEL_BASE     = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] filtered_data,
    input  logic        sample_valid,
    output logic        voice_active,
    output logic        voice_start,
    output logic [3:0]  level,
    output logic        level_valid
);
    // state  | meaning
    // SILENT | no voice, waiting for a loud window
    // ATTACK | loud run in progress, atk_rem more loud windows confirm voice
    // ACTIVE | voice declared
    // HANG   | voice still reported, hang_rem more quiet windows release it
    typedef enum logic [1:0] {SILENT, ATTACK, ACTIVE, HANG} state_t;

    localparam int ACC_W = 32 + WINDOW_LOG2;

    logic [31:0]            mag_q;
    logic                   mag_vld_q;
    logic [ACC_W-1:0]       acc_q;
    logic [WINDOW_LOG2-1:0] cnt_q;
    logic [ACC_W-1:0]       win_sum_q;
    logic                   done_q;

    state_t      state_q, state_d;
    logic [15:0] atk_rem_q, atk_rem_d;
    logic [15:0] hang_rem_q, hang_rem_d;
    logic [3:0]  level_q, level_d;
    logic        level_valid_q;
    logic        voice_start_q, voice_start_d;

    logic [ACC_W-1:0] acc_sum;
    logic [31:0]      mean;
    logic             loud, quiet;
    int               mean_msb;
    logic [3:0]       level_calc;

    assign acc_sum = acc_q + ACC_W'(mag_q);
    assign mean    = win_sum_q[ACC_W-1:WINDOW_LOG2];
    assign loud    = (mean >= ON_THRESH);
    assign quiet   = (mean < OFF_THRESH);

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q     <= '0;
            mag_vld_q <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            win_sum_q <= '0;
            done_q    <= 1'b0;
        end else begin
            mag_vld_q <= sample_valid;
            done_q    <= 1'b0;
            // 0x8000_0000 negates to itself, which is its correct unsigned magnitude
            if (sample_valid)
                mag_q <= filtered_data[31] ? (~filtered_data + 32'd1) : filtered_data;
            if (mag_vld_q) begin
                if (&cnt_q) begin
                    win_sum_q <= acc_sum;
                    acc_q     <= '0;
                    cnt_q     <= '0;
                    done_q    <= 1'b1;
                end else begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_q + WINDOW_LOG2'(1);
                end
            end
        end
    end

    always_comb begin
        mean_msb = -1;
        for (int i = 0; i < 32; i++)
            if (mean[i]) mean_msb = i;
        if (mean_msb >= LEVEL_BASE + 8)
            level_calc = 4'd9;
        else if (mean_msb >= LEVEL_BASE)
            level_calc = 4'(mean_msb - LEVEL_BASE + 1);
        else
            level_calc = 4'd0;
    end

    always_comb begin
        state_d       = state_q;
        atk_rem_d     = atk_rem_q;
        hang_rem_d    = hang_rem_q;
        level_d       = level_q;
        voice_start_d = 1'b0;
        if (done_q) begin
            level_d = level_calc;
            case (state_q)
                SILENT: begin
                    if (loud) begin
                        state_d   = ATTACK;
                        atk_rem_d = 16'(ATTACK_WINDOWS - 1);
                    end
                end
                ATTACK: begin
                    if (!loud) begin
                        state_d = SILENT;
                    end else if (atk_rem_q <= 16'd1) begin
                        state_d       = ACTIVE;
                        voice_start_d = 1'b1;
                    end else begin
                        atk_rem_d = atk_rem_q - 16'd1;
                    end
                end
                ACTIVE: begin
                    if (quiet) begin
                        state_d    = (HANG_WINDOWS <= 1) ? SILENT : HANG;
                        hang_rem_d = 16'(HANG_WINDOWS - 1);
                    end
                end
                HANG: begin
                    if (loud) begin
                        state_d = ACTIVE;
                    end else if (quiet) begin
                        if (hang_rem_q <= 16'd1) state_d = SILENT;
                        else hang_rem_d = hang_rem_q - 16'd1;
                    end
                end
                default: state_d = SILENT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SILENT;
            atk_rem_q     <= '0;
            hang_rem_q    <= '0;
            level_q       <= '0;
            level_valid_q <= 1'b0;
            voice_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            atk_rem_q     <= atk_rem_d;
            hang_rem_q    <= hang_rem_d;
            level_q       <= level_d;
            level_valid_q <= done_q;
            voice_start_q <= voice_start_d;
        end
    end

    assign voice_active = (state_q == ACTIVE) || (state_q == HANG);
    assign voice_start  = voice_start_q;
    assign level        = level_q;
    assign level_valid  = level_valid_q;

endmodule

// File: tb/tb_voice_activity_detector.sv
// Scoreboard bench: a window-level reference model queues expected closes; a monitor checks them.
module tb_voice_activity_detector;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int          WLOG   = 2;
    localparam int          WLEN   = 1 << WLOG;
    localparam longint      ON_T   = 64'h0010_0000;
    localparam longint      OFF_T  = 64'h0008_0000;
    localparam int          ATTACK = 2;
    localparam int          HANGW  = 4;
    localparam int          LBASE  = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] filtered_data = '0;
    logic        sample_valid = 1'b0;
    logic        voice_active, voice_start, level_valid;
    logic [3:0]  level;

    voice_activity_detector #(.WINDOW_LOG2(WLOG)) dut (
        .clk(clk), .rst(rst), .filtered_data(filtered_data), .sample_valid(sample_valid),
        .voice_active(voice_active), .voice_start(voice_start),
        .level(level), .level_valid(level_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] lvl;
        logic       active;
        logic       start;
        longint     t;
    } exp_t;

    exp_t   exp_q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    longint m_sum = 0;
    int     m_cnt = 0;
    bit     m_active = 0;
    int     m_loud_run = 0;
    int     m_quiet_run = 0;
    bit     rst_seen = 1'b1;
    logic   last_active = 1'b0;

    function automatic void check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: whole-window mean, threshold level table, and run-length voice decision.
    task automatic model_accept(input logic [31:0] d, input longint t_acc);
        longint v, mean;
        exp_t   e;
        bit     loud, quiet;
        v = longint'($signed(d));
        m_sum += (v < 0) ? -v : v;
        m_cnt++;
        if (m_cnt == WLEN) begin
            mean  = m_sum / WLEN;
            loud  = (mean >= ON_T);
            quiet = (mean < OFF_T);
            e.lvl = 4'd0;
            for (int k = 1; k <= 9; k++)
                if (mean >= (64'd1 << (LBASE + k - 1))) e.lvl = 4'(k);
            e.start = 1'b0;
            if (!m_active) begin
                m_loud_run = loud ? m_loud_run + 1 : 0;
                if (m_loud_run >= ATTACK) begin
                    m_active = 1; e.start = 1'b1; m_quiet_run = 0;
                end
            end else begin
                if (loud) m_quiet_run = 0;
                else if (quiet) m_quiet_run++;
                if (m_quiet_run >= HANGW) begin
                    m_active = 0; m_loud_run = 0; m_quiet_run = 0;
                end
            end
            e.active = m_active;
            e.t      = t_acc + 25;
            exp_q.push_back(e);
            m_sum = 0;
            m_cnt = 0;
        end
    endtask

    task automatic send(input logic [31:0] d, input int gap);
        repeat (gap) begin
            sample_valid  = 1'b0;
            filtered_data = $urandom;
            @(posedge clk); #1;
        end
        filtered_data = d;
        sample_valid  = 1'b1;
        @(posedge clk);
        model_accept(d, $time);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic send_window(input logic [31:0] d, input int gap);
        for (int i = 0; i < WLEN; i++) send(d, gap);
    endtask

    task automatic apply_reset(input int n);
        rst           = 1'b1;
        sample_valid  = 1'($urandom_range(0, 1));
        filtered_data = $urandom;
        // closes whose outputs would register at or after the first reset edge are cancelled
        while (exp_q.size() > 0 && (exp_q[$].t - 5) > $time) void'(exp_q.pop_back());
        m_sum = 0; m_cnt = 0; m_active = 0; m_loud_run = 0; m_quiet_run = 0;
        repeat (n) @(posedge clk);
        #1;
        rst          = 1'b0;
        sample_valid = 1'b0;
    endtask

    always @(posedge clk) rst_seen <= rst;

    always @(negedge clk) begin
        exp_t e;
        if (rst_seen) begin
            check("reset_voice_active", voice_active, 0);
            check("reset_voice_start", voice_start, 0);
            check("reset_level", level, 0);
            check("reset_level_valid", level_valid, 0);
            last_active = 1'b0;
        end else if (level_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_level_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("level", level, e.lvl);
                check("voice_active", voice_active, e.active);
                check("voice_start", voice_start, e.start);
                check("close_time", $time, e.t);
            end
            last_active = voice_active;
        end else begin
            check("start_without_close", voice_start, 0);
            check("active_changed_between_closes", voice_active, last_active);
        end
    end

    function automatic logic [31:0] rand_sample(input int cls);
        logic [31:0] m;
        case (cls)
            0:       m = $urandom_range(0, 32'h0007_FFFF);
            1:       m = $urandom_range(32'h0008_0000, 32'h000F_FFFF);
            2:       m = $urandom_range(32'h0010_0000, 32'h7FFF_FFFF) >> $urandom_range(0, 10);
            default: m = $urandom;
        endcase
        if (cls != 3 && $urandom_range(0, 1) == 1) m = ~m + 32'd1;
        return m;
    endfunction

    initial begin
        apply_reset(3);

        // reset mid-window discards the partial window
        for (int i = 0; i < 3; i++) send(32'h0100_0000, 0);
        apply_reset(2);
        send_window(32'h0020_0000, 0);

        // magnitude and accumulator width
        apply_reset(1);
        send(32'h0010_0000, 0);
        send(32'hFFF0_0000, 0);
        send(32'h7FFF_FFFF, 0);
        send(32'h8000_0000, 0);

        // attack: loud then quiet, then two loud
        apply_reset(1);
        send_window(32'h0020_0000, 0);
        send_window(32'h0000_0000, 0);
        send_window(32'h0020_0000, 0);
        send_window(32'hFFE0_0000, 0);

        // hysteresis and hang
        send_window(32'h000C_0000, 0);
        send_window(32'hFFF4_0000, 0);
        for (int i = 0; i < 4; i++) send_window(32'h0, 0);
        send_window(32'h0020_0000, 0);
        send_window(32'h0020_0000, 0);
        send_window(32'h0, 0);
        send_window(32'h0, 0);
        send_window(32'h0030_0000, 0);
        for (int i = 0; i < 4; i++) send_window(32'h0, 0);

        // gapped input, sample every 3rd cycle
        apply_reset(1);
        send(32'h0010_0000, 2);
        send(32'hFFF0_0000, 2);
        send(32'h7FFF_FFFF, 2);
        send(32'h8000_0000, 2);

        // reset on the cycle after the last sample of a window cancels the close
        apply_reset(1);
        for (int i = 0; i < 3; i++) send(32'h0040_0000, 0);
        send(32'h0040_0000, 0);
        apply_reset(1);
        repeat (4) @(posedge clk);
        #1;

        // randomized windows with gaps and occasional resets
        for (int w = 0; w < 150; w++) begin
            int cls;
            cls = $urandom_range(0, 3);
            for (int i = 0; i < WLEN; i++) begin
                send(rand_sample(($urandom_range(0, 7) == 0) ? 3 : cls), $urandom_range(0, 2));
                if ($urandom_range(0, 59) == 0) apply_reset($urandom_range(1, 3));
            end
        end

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("pending_closes_at_end", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
